// File: rtl/nes_phase_gen.sv
// nes_phase_gen: NES CPU phase-2 and PPU clock-enable generator.
// Divides the system clock into CPU cycles (ph2 rise/fall pulses and
// level) and PPU clock enables, with NTSC/PAL ratios, halt and cycle count.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   en_i           run enable; low freezes counters, suppresses pulses
//   mode_i         requested timing mode (0 NTSC, 1 PAL)
//   halt_req_i     level request to stop at next CPU cycle boundary
//   clr_cycles_i   synchronous clear of cpu_cycles_o
//   ph2_rising_o   one-clock pulse at start of CPU phase 2
//   ph2_falling_o  one-clock pulse at end of CPU cycle
//   ph2_o          phase-2 level
//   ppu_ce_o       one-clock PPU clock-enable pulse
//   halt_ack_o     high while halted
//   active_mode_o  timing mode currently in effect
//   cpu_cycles_o   completed CPU cycles, wrapping
module nes_phase_gen #(
    parameter int CPU_DIV0 = 12,
    parameter int CPU_DIV1 = 16,
    parameter int RISE0    = 6,
    parameter int RISE1    = 8,
    parameter int PPU_DIV0 = 4,
    parameter int PPU_DIV1 = 5,
    parameter int CYC_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             halt_req_i,
    input  logic             clr_cycles_i,
    output logic             ph2_rising_o,
    output logic             ph2_falling_o,
    output logic             ph2_o,
    output logic             ppu_ce_o,
    output logic             halt_ack_o,
    output logic             active_mode_o,
    output logic [CYC_W-1:0] cpu_cycles_o
);

    localparam int CPU_MAX = (CPU_DIV0 > CPU_DIV1) ? CPU_DIV0 : CPU_DIV1;
    localparam int PPU_MAX = (PPU_DIV0 > PPU_DIV1) ? PPU_DIV0 : PPU_DIV1;
    localparam int CW      = (CPU_MAX > 2) ? $clog2(CPU_MAX) : 1;
    localparam int PW      = (PPU_MAX > 2) ? $clog2(PPU_MAX) : 1;

    localparam logic [CW-1:0] DIV0_M1 = CW'(CPU_DIV0 - 1);
    localparam logic [CW-1:0] DIV1_M1 = CW'(CPU_DIV1 - 1);
    localparam logic [CW-1:0] RISE0_V = CW'(RISE0);
    localparam logic [CW-1:0] RISE1_V = CW'(RISE1);
    localparam logic [PW-1:0] PPU0_M1 = PW'(PPU_DIV0 - 1);
    localparam logic [PW-1:0] PPU1_M1 = PW'(PPU_DIV1 - 1);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cpu_cnt_q, cpu_cnt_d;
    logic [PW-1:0]    ppu_cnt_q, ppu_cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ph2_q, ph2_d;
    logic             ppu_ce_q, ppu_ce_d;
    logic             mode_q, mode_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic          run;
    logic [CW-1:0] div_m1;
    logic [CW-1:0] rise_v;
    logic [PW-1:0] ppu_m1;
    logic          at_rise;
    logic          at_bnd;
    logic          at_ppu;
    logic          bnd_edge;
    logic          mode_load;
    logic          mode_chg;
    logic          zero_cnt;

    // Timing constants follow the mode in effect, not the requested one.
    always_comb begin
        run      = en_i && (state_q == S_RUN);
        div_m1   = mode_q ? DIV1_M1 : DIV0_M1;
        rise_v   = mode_q ? RISE1_V : RISE0_V;
        ppu_m1   = mode_q ? PPU1_M1 : PPU0_M1;
        at_rise  = (cpu_cnt_q == rise_v);
        at_bnd   = (cpu_cnt_q == div_m1);
        at_ppu   = (ppu_cnt_q == ppu_m1);
        bnd_edge = run && at_bnd;
    end

    // Mode switches only on a clean cycle boundary or while stopped,
    // so a CPU cycle never mixes two timings.
    always_comb begin
        mode_load = bnd_edge || (state_q == S_HALTED);
        mode_chg  = mode_load && (mode_i != mode_q);
    end

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; halt is only honoured at a boundary reached
    // while enabled, so a disabled block never halts mid-cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (bnd_edge && halt_req_i) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!halt_req_i) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        halt_ack_o = (state_q == S_HALTED);
    end

    // Counters restart from zero on a mode change and are parked at
    // zero while halted, so resume timing matches post-reset timing.
    always_comb begin
        zero_cnt  = mode_chg || (state_d == S_HALTED);

        cpu_cnt_d = cpu_cnt_q;
        if (run) begin
            cpu_cnt_d = at_bnd ? '0 : cpu_cnt_q + CW'(1);
        end
        if (zero_cnt) begin
            cpu_cnt_d = '0;
        end

        ppu_cnt_d = ppu_cnt_q;
        if (run) begin
            ppu_cnt_d = at_ppu ? '0 : ppu_cnt_q + PW'(1);
        end
        if (zero_cnt) begin
            ppu_cnt_d = '0;
        end
    end

    // Pulses are one clock wide and only produced on running edges.
    // ph2 drops on the first running edge after the boundary, which
    // keeps it high through the ph2_falling clock and holds it while
    // disabled or halted.
    always_comb begin
        rise_d   = run && at_rise;
        fall_d   = bnd_edge;
        ppu_ce_d = run && at_ppu;

        ph2_d = ph2_q;
        if (run) begin
            if (at_rise) begin
                ph2_d = 1'b1;
            end else if (cpu_cnt_q == '0) begin
                ph2_d = 1'b0;
            end
        end

        mode_d = mode_load ? mode_i : mode_q;

        cyc_d = cyc_q;
        if (clr_cycles_i) begin
            cyc_d = '0;
        end else if (bnd_edge) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_cnt_q <= '0;
            ppu_cnt_q <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            ph2_q     <= 1'b0;
            ppu_ce_q  <= 1'b0;
            mode_q    <= 1'b0;
            cyc_q     <= '0;
        end else begin
            cpu_cnt_q <= cpu_cnt_d;
            ppu_cnt_q <= ppu_cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            ph2_q     <= ph2_d;
            ppu_ce_q  <= ppu_ce_d;
            mode_q    <= mode_d;
            cyc_q     <= cyc_d;
        end
    end

    always_comb begin
        ph2_rising_o  = rise_q;
        ph2_falling_o = fall_q;
        ph2_o         = ph2_q;
        ppu_ce_o      = ppu_ce_q;
        active_mode_o = mode_q;
        cpu_cycles_o  = cyc_q;
    end

endmodule

// File: tb/tb_nes_phase_gen.sv
// tb_nes_phase_gen: self-checking bench for nes_phase_gen.
// Event edges are queued as expectations and matched against pulses seen.
module tb_nes_phase_gen;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic          halt_req;
    logic          clr;
    logic          rise;
    logic          fall;
    logic          ph2;
    logic          ppu;
    logic          ack;
    logic          amode;
    logic [CW-1:0] cyc;

    always #5 clk = ~clk;

    nes_phase_gen #(.CYC_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .mode_i       (mode),
        .halt_req_i   (halt_req),
        .clr_cycles_i (clr),
        .ph2_rising_o (rise),
        .ph2_falling_o(fall),
        .ph2_o        (ph2),
        .ppu_ce_o     (ppu),
        .halt_ack_o   (ack),
        .active_mode_o(amode),
        .cpu_cycles_o (cyc)
    );

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    int exp_rise[$];
    int exp_fall[$];
    int exp_ppu[$];
    int act_rise[$];
    int act_fall[$];
    int act_ppu[$];

    logic          ph2_at [0:255];
    logic          ack_at [0:255];
    logic          mode_at[0:255];
    logic [CW-1:0] cyc_at [0:255];

    // sig: 0 ph2, 1 cpu_cycles, 2 halt_ack, 3 active_mode
    typedef struct {
        int e;
        int sig;
        int val;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
        if (rise) act_rise.push_back(ecnt);
        if (fall) act_fall.push_back(ecnt);
        if (ppu) act_ppu.push_back(ecnt);
        if (ecnt < 256) begin
            ph2_at[ecnt]  = ph2;
            ack_at[ecnt]  = ack;
            mode_at[ecnt] = amode;
            cyc_at[ecnt]  = cyc;
        end
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        en       = 1'b1;
        mode     = 1'b0;
        halt_req = 1'b0;
        clr      = 1'b0;
        #2;
        rst  = 1'b0;
        ecnt = 0;
        act_rise.delete();
        act_fall.delete();
        act_ppu.delete();
    endtask

    task automatic cmp_events(input string tn);
        int a;
        while (exp_rise.size() > 0) begin
            a = (act_rise.size() > 0) ? act_rise.pop_front() : -1;
            check({tn, " ph2_rising edge"}, a, exp_rise.pop_front());
        end
        check({tn, " extra ph2_rising"}, act_rise.size(), 0);
        while (exp_fall.size() > 0) begin
            a = (act_fall.size() > 0) ? act_fall.pop_front() : -1;
            check({tn, " ph2_falling edge"}, a, exp_fall.pop_front());
        end
        check({tn, " extra ph2_falling"}, act_fall.size(), 0);
        while (exp_ppu.size() > 0) begin
            a = (act_ppu.size() > 0) ? act_ppu.pop_front() : -1;
            check({tn, " ppu_ce edge"}, a, exp_ppu.pop_front());
        end
        check({tn, " extra ppu_ce"}, act_ppu.size(), 0);
    endtask

    task automatic check_tbl(input string tn);
        logic [31:0] a;
        string       sn;
        foreach (tbl[i]) begin
            a  = 'x;
            sn = "?";
            case (tbl[i].sig)
                0: begin a = 32'(ph2_at[tbl[i].e]);  sn = "ph2"; end
                1: begin a = 32'(cyc_at[tbl[i].e]);  sn = "cpu_cycles"; end
                2: begin a = 32'(ack_at[tbl[i].e]);  sn = "halt_ack"; end
                default: begin a = 32'(mode_at[tbl[i].e]); sn = "active_mode"; end
            endcase
            check($sformatf("%s %s@%0d", tn, sn, tbl[i].e), a, tbl[i].val);
        end
        tbl.delete();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        halt_req = 1'b0;
        clr      = 1'b0;
        #3;
        check("reset ph2", 32'(ph2), 0);
        check("reset halt_ack", 32'(ack), 0);
        check("reset cpu_cycles", 32'(cyc), 0);

        // Mode 0 from reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_rise.push_back(7 + 12 * k);
            exp_fall.push_back(12 + 12 * k);
        end
        for (int k = 1; k <= 12; k++) exp_ppu.push_back(4 * k);
        tbl.push_back('{6, 0, 0});
        tbl.push_back('{7, 0, 1});
        tbl.push_back('{12, 0, 1});
        tbl.push_back('{13, 0, 0});
        tbl.push_back('{11, 1, 0});
        tbl.push_back('{12, 1, 1});
        tbl.push_back('{48, 1, 4});
        tbl.push_back('{48, 3, 0});
        run_to(48);
        cmp_events("ntsc");
        check_tbl("ntsc");

        // Switch to PAL mid-cycle
        do_reset();
        exp_rise = '{7, 21, 37};
        exp_fall = '{12, 28, 44};
        exp_ppu  = '{4, 8, 12, 17, 22, 27, 32, 37, 42};
        tbl.push_back('{11, 3, 0});
        tbl.push_back('{12, 3, 1});
        tbl.push_back('{20, 0, 0});
        tbl.push_back('{21, 0, 1});
        tbl.push_back('{28, 0, 1});
        tbl.push_back('{29, 0, 0});
        run_to(3);
        mode = 1'b1;
        run_to(44);
        cmp_events("pal");
        check_tbl("pal");

        // Halt and resume
        do_reset();
        exp_rise = '{7, 60};
        exp_fall = '{12, 65};
        exp_ppu  = '{4, 8, 12, 57, 61, 65};
        tbl.push_back('{11, 2, 0});
        tbl.push_back('{12, 2, 1});
        tbl.push_back('{52, 2, 1});
        tbl.push_back('{53, 2, 0});
        tbl.push_back('{52, 0, 1});
        tbl.push_back('{54, 0, 0});
        tbl.push_back('{52, 1, 1});
        run_to(2);
        halt_req = 1'b1;
        run_to(52);
        halt_req = 1'b0;
        run_to(65);
        cmp_events("halt");
        check_tbl("halt");

        // Enable low for 5 clocks mid-cycle
        do_reset();
        exp_rise = '{12, 24};
        exp_fall = '{17, 29};
        exp_ppu  = '{4, 13, 17, 21, 25, 29};
        tbl.push_back('{9, 0, 0});
        tbl.push_back('{12, 0, 1});
        tbl.push_back('{17, 0, 1});
        tbl.push_back('{18, 0, 0});
        tbl.push_back('{17, 1, 1});
        run_to(4);
        en = 1'b0;
        run_to(9);
        en = 1'b1;
        run_to(29);
        cmp_events("enable");
        check_tbl("enable");

        // Cycle counter wrap and clear priority
        do_reset();
        tbl.push_back('{180, 1, 15});
        tbl.push_back('{191, 1, 15});
        tbl.push_back('{192, 1, 0});
        tbl.push_back('{204, 1, 0});
        tbl.push_back('{216, 1, 1});
        run_to(203);
        clr = 1'b1;
        run_to(204);
        clr = 1'b0;
        run_to(216);
        check_tbl("wrap");

        // Asynchronous reset while halted with ph2 high
        do_reset();
        halt_req = 1'b1;
        run_to(15);
        check("pre-rst ph2", 32'(ph2), 1);
        check("pre-rst halt_ack", 32'(ack), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async ph2", 32'(ph2), 0);
        check("async halt_ack", 32'(ack), 0);
        check("async ph2_rising", 32'(rise), 0);
        check("async ph2_falling", 32'(fall), 0);
        check("async ppu_ce", 32'(ppu), 0);
        check("async active_mode", 32'(amode), 0);
        check("async cpu_cycles", 32'(cyc), 0);
        #1;
        rst      = 1'b0;
        halt_req = 1'b0;
        ecnt     = 0;
        act_rise.delete();
        act_fall.delete();
        act_ppu.delete();
        exp_rise = '{7};
        exp_fall = '{12};
        exp_ppu  = '{4, 8, 12};
        tbl.push_back('{1, 2, 0});
        tbl.push_back('{13, 2, 0});
        run_to(13);
        cmp_events("rst-halt");
        check_tbl("rst-halt");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_phase_gen.md
NES_PHASE_GEN -- requirements
Module: nes_phase_gen

Interface
REQ-001 SHALL have parameter CPU_DIV0, default 12, CPU clock divide ratio in mode 0 (NTSC).
REQ-002 SHALL have parameter CPU_DIV1, default 16, CPU clock divide ratio in mode 1 (PAL).
REQ-003 SHALL have parameters RISE0/RISE1, default 6/8, counter value producing ph2_rising in mode 0/1; legal range 1 <= RISEn < CPU_DIVn-1.
REQ-004 SHALL have parameters PPU_DIV0/PPU_DIV1, default 4/5, PPU clock-enable divide ratio in mode 0/1; each >= 2.
REQ-005 SHALL have parameter CYC_W, default 32, width of cpu_cycles.
REQ-006 clk  in  1  system clock; the block has one clock.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 en  in  1  run enable; low freezes all counters and suppresses all pulses.
REQ-009 mode  in  1  requested timing mode (0 NTSC, 1 PAL).
REQ-010 halt_req  in  1  level request to stop at the next CPU cycle boundary.
REQ-011 clr_cycles  in  1  synchronous clear of cpu_cycles.
REQ-012 ph2_rising  out  1  one-clock pulse, start of CPU phase 2.
REQ-013 ph2_falling  out  1  one-clock pulse, end of CPU cycle.
REQ-014 ph2  out  1  phase-2 level.
REQ-015 ppu_ce  out  1  one-clock PPU clock-enable pulse.
REQ-016 halt_ack  out  1  high while halted.
REQ-017 active_mode  out  1  mode currently in effect.
REQ-018 cpu_cycles  out  CYC_W  count of completed CPU cycles, wraps.

Function
REQ-019 "run" = en AND state RUN; DIV/RISE/PPU_DIV = values selected by active_mode.
REQ-020 cpu_cnt (internal) SHALL count 0..DIV-1 when run, wrapping DIV-1 -> 0; hold otherwise.
REQ-021 ph2_rising SHALL be registered: high for one clock after an edge where run AND cpu_cnt==RISE.
REQ-022 ph2_falling SHALL be registered: high for one clock after an edge where run AND cpu_cnt==DIV-1 (the "boundary").
REQ-023 ph2 SHALL be high from the clock ph2_rising is high through the clock ph2_falling is high inclusive; holds value while not run.
REQ-024 ppu_cnt SHALL count 0..PPU_DIV-1 when run, independent of cpu_cnt; ppu_ce registered, high one clock after an edge where run AND ppu_cnt==PPU_DIV-1.
REQ-025 active_mode SHALL load mode only at a boundary edge or at any edge while HALTED; on a change, ppu_cnt and cpu_cnt load 0 on that edge.
REQ-026 States RUN, HALTED; RUN -> HALTED at a boundary edge with halt_req=1 (cpu_cnt -> 0); HALTED -> RUN on first edge with halt_req=0.
REQ-027 halt_ack SHALL rise on the same edge as the final ph2_falling and fall on the HALTED -> RUN edge; counters hold 0 and no pulses while HALTED.
REQ-028 After HALTED -> RUN, first ph2_rising SHALL appear RISE+1 edges later (identical to post-reset timing).
REQ-029 cpu_cycles SHALL increment on each edge that sets ph2_falling, wrapping 2^CYC_W-1 -> 0.
REQ-030 clr_cycles SHALL zero cpu_cycles next edge; clear wins over simultaneous increment.
REQ-031 en low mid-cycle SHALL stretch the current CPU and PPU periods by exactly the number of low clocks; state and halt_ack unchanged.
REQ-032 halt_req asserted while en=0 SHALL take effect only at the next boundary reached with en=1.

Reset
REQ-033 rst high SHALL immediately, without a clock edge, force: cpu_cnt=0, ppu_cnt=0, ph2_rising=0, ph2_falling=0, ph2=0, ppu_ce=0, state RUN, halt_ack=0, active_mode=0, cpu_cycles=0.
REQ-034 Reset asserted mid-cycle or while HALTED SHALL abandon the operation; no pulse is emitted for the partial cycle.

Verification
REQ-035 Release rst, en=1, mode=0 -> ph2_rising on 7th edge, ph2_falling on 12th, period 12; ppu_ce on 4th edge, period 4; cpu_cycles=1 after first ph2_falling.
REQ-036 mode=1 driven at cpu_cnt=3 -> mode 0 timing until next ph2_falling, then active_mode=1, ph2 period 16 (rise at count 8), ppu_ce period 5.
REQ-037 halt_req=1 at cpu_cnt=2 -> halt_ack rises with next ph2_falling, zero pulses for 40 clocks held; halt_req=0 -> halt_ack falls, ph2_rising 7 edges later.
REQ-038 en=0 for 5 clocks at cpu_cnt=4 (mode 0) -> ph2 period measured as 17 clocks, ph2 level held, no pulses while low.
REQ-039 CYC_W=4: 16 CPU cycles -> cpu_cycles wraps 15 -> 0; clr_cycles coincident with ph2_falling -> cpu_cycles=0.
REQ-040 rst pulsed between clock edges while HALTED with ph2=1 -> all outputs 0 before the next edge; state RUN after release.
